// File: rtl/ppe_pkg.sv
// ppe_pkg: shared constants, FSM state type and index helpers for the round-robin arbiter
package ppe_pkg;
  localparam int PPE_WIDTH = 512;
  localparam int MAX_W = 1024;
  typedef enum logic {IDLE, HOLD} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  // Encoders zero-extend to MAX_W, so WIDTH must not exceed it
  function automatic int onehot_to_idx(input logic [MAX_W-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < MAX_W; i++) if (oh[i]) r |= i;
    return r;
  endfunction
endpackage

// File: rtl/ppe_core.sv
// ppe_core: combinational programmable priority encoder, first request at or above P_enc with wrap
module ppe_core
  import ppe_pkg::*;
#(
  parameter int WIDTH = PPE_WIDTH,
  localparam int IDXW = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] Req,
  input  logic [IDXW-1:0]  P_enc,
  output logic [IDXW-1:0]  o_value,
  output logic             valid
);
  logic [WIDTH-1:0] masked, sel, onehot;
  always_comb begin
    masked = Req & ({WIDTH{1'b1}} << P_enc);
    sel = |masked ? masked : Req;
    onehot = sel & (~sel + WIDTH'(1));
    o_value = IDXW'(onehot_to_idx(MAX_W'(onehot)));
    valid = |Req;
  end
endmodule

// File: rtl/ppe_rr_arbiter.sv
// ppe_rr_arbiter: round-robin / programmable-priority arbiter with a registered valid/ready grant
module ppe_rr_arbiter
  import ppe_pkg::*;
#(
  parameter int WIDTH = PPE_WIDTH,
  localparam int IDXW = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] Req,
  input  logic             Rr_en,
  input  logic             Pri_load,
  input  logic [IDXW-1:0]  Pri_value,
  output logic             Gnt_valid,
  input  logic             Gnt_ready,
  output logic [IDXW-1:0]  Gnt_idx,
  output logic [WIDTH-1:0] Gnt_onehot,
  output logic [IDXW-1:0]  Ptr
);
  state_t state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d, idx_q, idx_d, win_idx;
  logic [WIDTH-1:0] onehot_q, onehot_d;
  logic accept, load, win_valid;
  ppe_core #(.WIDTH(WIDTH)) u_core (
    .Req(Req),
    .P_enc(ptr_d),
    .o_value(win_idx),
    .valid(win_valid)
  );
  always_comb begin
    accept = (state_q == HOLD) && Gnt_ready;
    ptr_d = Pri_load ? Pri_value : (accept && Rr_en) ? idx_q + IDXW'(1) : ptr_q;
    load = ((state_q == IDLE) || accept) && win_valid;
    state_d = load ? HOLD : accept ? IDLE : state_q;
    idx_d = load ? win_idx : idx_q;
    onehot_d = load ? (WIDTH'(1) << win_idx) : accept ? '0 : onehot_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      idx_q <= '0;
      onehot_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      onehot_q <= onehot_d;
    end
  end
  assign Gnt_valid = (state_q == HOLD);
  assign Gnt_idx = idx_q;
  assign Gnt_onehot = onehot_q;
  assign Ptr = ptr_q;
endmodule

// File: tb/tb_ppe_rr_arbiter.sv
// tb_ppe_rr_arbiter: randomized and directed scoreboard bench against a search-based reference model
module tb_ppe_rr_arbiter;
  localparam int W = 512;
  localparam int W16 = 16;
  typedef struct {logic v; int idx; int ptr;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1, rr_en = 1'b1, pri_load = 1'b0, gnt_ready = 1'b0;
  logic [W-1:0] req = '0;
  logic [8:0] pri_value = '0;
  logic gnt_valid;
  logic [8:0] gnt_idx, ptr;
  logic [W-1:0] gnt_onehot;
  logic rst16 = 1'b1, rdy16 = 1'b0;
  logic [W16-1:0] req16 = '0;
  logic g16_valid;
  logic [3:0] g16_idx, ptr16;
  logic [W16-1:0] g16_onehot;
  int checks = 0, errors = 0;
  exp_t q[$];
  int m_ptr = 0, m_idx = 0;
  logic m_valid = 1'b0;
  logic fair_on = 1'b0;
  int acc = 0;
  int cnt[W];

  ppe_rr_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Req(req), .Rr_en(rr_en), .Pri_load(pri_load),
    .Pri_value(pri_value), .Gnt_valid(gnt_valid), .Gnt_ready(gnt_ready),
    .Gnt_idx(gnt_idx), .Gnt_onehot(gnt_onehot), .Ptr(ptr)
  );
  ppe_rr_arbiter #(.WIDTH(W16)) dut16 (
    .clk(clk), .rst(rst16), .Req(req16), .Rr_en(1'b1), .Pri_load(1'b0),
    .Pri_value(4'd0), .Gnt_valid(g16_valid), .Gnt_ready(rdy16),
    .Gnt_idx(g16_idx), .Gnt_onehot(g16_onehot), .Ptr(ptr16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, act, exp);
    end
  endtask

  // Search upward from p, wrapping, for the first asserted request
  function automatic int winner(input logic [W-1:0] r, input int p, input int w);
    for (int k = 0; k < w; k++) if (r[(p + k) % w]) return (p + k) % w;
    return -1;
  endfunction

  function automatic logic [W-1:0] bits(input int a, input int b, input int c);
    logic [W-1:0] r;
    r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  // Drive one cycle of inputs (called at a falling edge) and predict the state after the next rising edge
  task automatic step(input logic r, input logic [W-1:0] rq, input logic rr, input logic pl,
                      input int pv, input logic rd);
    int p, w;
    logic a;
    rst = r; req = rq; rr_en = rr; pri_load = pl; pri_value = 9'(pv); gnt_ready = rd;
    if (r) begin
      m_ptr = 0; m_valid = 1'b0; m_idx = 0;
    end else begin
      a = m_valid && rd;
      p = pl ? pv : (a && rr) ? (m_idx + 1) % W : m_ptr;
      w = winner(rq, p, W);
      if (!m_valid || a) begin
        if (w >= 0) begin
          m_valid = 1'b1; m_idx = w;
        end else m_valid = 1'b0;
      end
      m_ptr = p;
    end
    q.push_back('{m_valid, m_idx, m_ptr});
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    logic pv;
    int pi;
    pv = 1'b0; pi = 0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("valid", W'(gnt_valid), W'(e.v));
        chk("idx", W'(gnt_idx), W'(e.idx));
        chk("ptr", W'(ptr), W'(e.ptr));
        chk("onehot", gnt_onehot, e.v ? (W'(1) << e.idx) : '0);
      end
      if (fair_on && !rst && pv && gnt_ready && acc < W) begin
        cnt[pi]++;
        acc++;
      end
      pv = gnt_valid; pi = int'(gnt_idx);
    end
  end

  initial begin
    int c16[W16];
    int k, bad;
    logic [W-1:0] r;
    step(1, '0, 1, 0, 0, 0);
    step(1, '0, 1, 0, 0, 0);
    repeat (5) step(0, '0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, bits(3, 100, 511), 1, 0, 0, 1);
    step(0, '0, 1, 0, 0, 1);
    step(0, '0, 1, 0, 0, 1);
    step(0, bits(10, 300, -1), 1, 1, 400, 1);
    step(0, '0, 1, 0, 0, 1);
    step(0, '0, 1, 0, 0, 1);
    step(0, bits(5, -1, -1), 1, 0, 0, 0);
    step(0, bits(5, -1, -1), 1, 0, 0, 0);
    step(0, bits(200, -1, -1), 1, 0, 0, 0);
    step(0, bits(200, -1, -1), 1, 1, 150, 0);
    step(0, bits(200, -1, -1), 1, 0, 0, 0);
    step(0, bits(200, -1, -1), 1, 0, 0, 0);
    step(0, bits(200, -1, -1), 1, 0, 0, 1);
    step(0, '0, 1, 0, 0, 1);
    step(0, '0, 1, 0, 0, 1);
    step(0, '0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(0, bits(7, 8, -1), 0, 0, 0, 1);
    step(0, bits(5, 9, -1), 1, 1, 300, 0);
    step(0, bits(5, 9, -1), 1, 0, 0, 0);
    step(1, bits(5, 9, -1), 1, 1, 300, 1);
    step(0, bits(5, 9, -1), 1, 0, 0, 1);
    step(0, bits(5, 9, -1), 1, 0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0)
        r = bits($urandom_range(0, 511), $urandom_range(0, 1) ? int'($urandom_range(0, 511)) : -1, -1);
      else for (int j = 0; j < W / 32; j++) r[j*32 +: 32] = $urandom();
      if ($urandom_range(0, 9) == 0) r = '0;
      step($urandom_range(0, 49) == 0, r, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 511), $urandom_range(0, 3) != 0);
    end
    step(1, '0, 1, 0, 0, 0);
    for (int i = 0; i < W; i++) cnt[i] = 0;
    acc = 0;
    fair_on = 1'b1;
    for (int c = 0; c < 3000 && acc < W; c++) step(0, '1, 1, 0, 0, $urandom_range(0, 1));
    step(0, '0, 1, 0, 0, 1);
    fair_on = 1'b0;
    chk("fair_accepts", W'(acc), W'(W));
    bad = 0;
    for (int i = 0; i < W; i++) if (cnt[i] != 1) bad++;
    chk("fair_once_each", W'(bad), '0);
    step(0, '0, 1, 0, 0, 1);
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    rst16 = 1'b0; req16 = '1; k = 0;
    for (int i = 0; i < W16; i++) c16[i] = 0;
    begin : rr16
      logic pv;
      int pi;
      pv = 1'b0; pi = 0;
      for (int c = 0; c < 400 && k < 2 * W16; c++) begin
        rdy16 = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        if (pv && rdy16) begin
          chk("rr16_idx", W'(pi), W'(k % W16));
          c16[pi]++;
          k++;
        end
        pv = g16_valid; pi = int'(g16_idx);
        @(negedge clk);
      end
    end
    chk("rr16_accepts", W'(k), W'(2 * W16));
    bad = 0;
    for (int i = 0; i < W16; i++) if (c16[i] != 2) bad++;
    chk("rr16_fair", W'(bad), '0);
    chk("sb_drained", W'(q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ppe_rr_arbiter.md
Name: ppe_rr_arbiter

Overview:
Parametrised round-robin arbiter built around a programmable priority encoder (PPE). Each cycle it selects the first asserted request at or above a stored priority pointer, wrapping past the top index. The selection is registered and presented on a valid/ready grant interface. On acceptance the pointer advances past the winner (round-robin), or it can be frozen or loaded by software (fixed programmable priority).

Parameters:
- WIDTH, 512, number of requesters; power of 2, minimum 4.
- IDXW, $clog2(WIDTH), width of pointer and index; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Req  in  WIDTH  request vector; level-sensitive; bit i is requester i.
- Rr_en  in  1  1 = pointer advances on grant accept; 0 = pointer holds (fixed-priority mode).
- Pri_load  in  1  load Pri_value into the pointer this cycle.
- Pri_value  in  IDXW  new pointer value (highest-priority index).
- Gnt_valid  out  1  a grant is held on Gnt_idx/Gnt_onehot.
- Gnt_ready  in  1  consumer accepts the held grant.
- Gnt_idx  out  IDXW  index of the granted requester.
- Gnt_onehot  out  WIDTH  one-hot form of Gnt_idx; all zero when Gnt_valid = 0.
- Ptr  out  IDXW  current pointer, for debug and status.

Behaviour:
- Reset (clk edge with rst = 1):
  - Ptr = 0, Gnt_valid = 0, Gnt_idx = 0, Gnt_onehot = 0, state = IDLE.
  - Reset overrides Pri_load and any handshake in the same cycle.
- PPE function: with pointer p, the winner is the lowest index i >= p with Req[i] = 1. If none exists, it is the lowest index i < p with Req[i] = 1. If Req = 0 there is no winner.
- Effective pointer p_eff, evaluated combinationally each cycle:
  - Pri_load = 1: p_eff = Pri_value.
  - Otherwise, accept this cycle and Rr_en = 1: p_eff = (Gnt_idx + 1) mod WIDTH.
  - Otherwise: p_eff = Ptr.
- Ptr <= p_eff every cycle. Pri_load wins over a simultaneous round-robin advance. Index WIDTH-1 + 1 wraps to 0.
- State machine:
  - IDLE (Gnt_valid = 0): if Req != 0, register PPE(Req, p_eff) into Gnt_idx/Gnt_onehot, set Gnt_valid = 1, go to HOLD. Request-to-grant latency is 1 cycle. If Req = 0, stay in IDLE.
  - HOLD (Gnt_valid = 1): Gnt_idx and Gnt_onehot stay stable until accept (Gnt_valid & Gnt_ready). Withdrawing Req[Gnt_idx] does not retract the grant. Pri_load in HOLD changes Ptr only; the held grant is untouched.
  - HOLD with accept: if Req != 0, load PPE(Req, p_eff) in the same edge and stay in HOLD (back-to-back, no bubble). If Req = 0, clear Gnt_valid and Gnt_onehot and go to IDLE; Gnt_idx keeps its last value.
- The same index may be re-granted back-to-back only if it is the sole requester, or if Rr_en = 0 and it is still highest priority.
- Fairness: with Rr_en = 1 and all WIDTH requests held high, every index is granted exactly once per WIDTH accepts.
- No X on any output after reset, for any input sequence.

Decomposition:
- Package ppe_pkg holds:
  - the default WIDTH constant (512);
  - a clog2 helper function;
  - a one-hot-to-index function shared with the encoder.
- Sub-module ppe_core: purely combinational PPE generalised to WIDTH.
  - Ports: Req, P_enc, o_value, valid.
  - Implementation: thermometer mask of P_enc, a masked and an unmasked simple priority encoder, select masked if any masked request else unmasked, then encode.
- ppe_rr_arbiter instantiates one ppe_core and owns the pointer, the FSM and the output registers.

Test Plan:
- Reset, then Req = 0 for 5 cycles -> Gnt_valid = 0, Gnt_onehot = 0, Ptr = 0 throughout.
- Ptr = 0, Req bits {3, 100, 511} held high, Rr_en = 1, Gnt_ready = 1 -> grants 3, 100, 511, 3 on consecutive cycles; Ptr steps 4, 101, 0, 4.
- Pri_load = 1, Pri_value = 400, Req bits {10, 300} -> grant 10 (wrap past 511); Ptr = 11 after accept.
- Gnt_ready = 0 for 6 cycles while Req changes from {5} to {200} and Pri_load = 1, Pri_value = 150 mid-hold -> Gnt_idx holds 5; after accept, grant 200 and Ptr = 201.
- Rr_en = 0, Ptr = 0, Req bits {7, 8} held, Gnt_ready = 1 -> grant 7 on every cycle; Ptr stays 0.
- rst asserted while Gnt_valid = 1, same cycle as Gnt_ready = 1 and Pri_load = 1 -> next cycle Gnt_valid = 0, Ptr = 0; first grant after reset uses Ptr = 0.
- All 512 Req bits held, Rr_en = 1, random Gnt_ready -> each index granted exactly once per 512 accepts; rerun the same checks with WIDTH = 16.
